// File: rtl/mul4_dot_acc.sv
// Sequential dot-product stage: accumulates N unsigned 4x4 products per group
// and presents the wrapped sum plus a sticky carry flag over valid/ready.
module mul4_dot_acc #(
  parameter int unsigned N     = 4,
  parameter int unsigned ACC_W = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       x,
  input  logic [3:0]       y,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_sum,
  output logic             out_ovf
);

  localparam int unsigned CNT_W  = $clog2(N) + 1;
  localparam int unsigned SUM_W  = ACC_W + 1;
  localparam int unsigned PROD_W = 8;

  typedef enum logic {
    S_ACC  = 1'b0,
    S_HOLD = 1'b1
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [CNT_W-1:0]   r_cnt;
  logic [ACC_W-1:0]   r_acc;
  logic               r_ovf;
  logic               r_in_ready;
  logic               r_out_valid;

  logic [PROD_W-1:0]  w_prod;
  logic [ACC_W-1:0]   w_acc_base;
  logic [SUM_W-1:0]   w_sum;
  logic               w_in_fire;
  logic               w_out_fire;
  logic               w_last;
  logic               w_in_ready_d;
  logic               w_out_valid_d;

  // 4x4 unsigned multiplier; full 8-bit product, no truncation possible
  assign w_prod     = PROD_W'(x) * PROD_W'(y);

  assign w_in_fire  = in_valid & r_in_ready;
  assign w_out_fire = r_out_valid & out_ready;
  assign w_last     = (r_cnt == CNT_W'(N - 1));

  // First product of a group restarts the sum, so no explicit clear on drain
  assign w_acc_base = (r_cnt == '0) ? '0 : r_acc;
  assign w_sum      = SUM_W'(w_acc_base) + SUM_W'(w_prod);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_ACC;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_ACC:   if (w_in_fire && w_last) w_state_nxt = S_HOLD;
      S_HOLD:  if (w_out_fire)          w_state_nxt = S_ACC;
      default: w_state_nxt = S_ACC;
    endcase
  end

  // Output decode of the upcoming state; registered below
  always_comb begin
    w_in_ready_d  = 1'b0;
    w_out_valid_d = 1'b0;
    case (w_state_nxt)
      S_ACC:   w_in_ready_d  = 1'b1;
      S_HOLD:  w_out_valid_d = 1'b1;
      default: w_in_ready_d  = 1'b0;
    endcase
  end

  // Handshake flags held low through reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      r_in_ready  <= w_in_ready_d;
      r_out_valid <= w_out_valid_d;
    end
  end

  // Accumulator datapath
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
      r_acc <= '0;
      r_ovf <= 1'b0;
    end else if (w_in_fire) begin
      r_acc <= w_sum[ACC_W-1:0];
      r_ovf <= ((r_cnt == '0) ? 1'b0 : r_ovf) | w_sum[ACC_W];
      r_cnt <= w_last ? '0 : (r_cnt + CNT_W'(1));
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out_sum   = r_acc;
  assign out_ovf   = r_ovf;

endmodule

// File: tb/tb_mul4_dot_acc.sv
// Scoreboard bench for mul4_dot_acc: three configurations (N=4/W=10, N=4/W=8,
// N=1/W=10) share clock and reset; monitors pop expected results on each output handshake.
module tb_mul4_dot_acc;

  typedef struct {
    int sum;
    int ovf;
  } exp_t;

  logic       clk;
  logic       rst_n;
  logic [2:0] iv;
  logic [2:0] ird;
  logic [2:0] ov;
  logic [2:0] ordy;
  logic [2:0] ovf;
  logic [3:0] tx [3];
  logic [3:0] ty [3];
  logic [9:0] sum0;
  logic [7:0] sum1;
  logic [9:0] sum2;

  exp_t q0[$];
  exp_t q1[$];
  exp_t q2[$];

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  mul4_dot_acc #(.N(4), .ACC_W(10)) u_d0 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(ird[0]),
    .x(tx[0]), .y(ty[0]), .out_valid(ov[0]), .out_ready(ordy[0]),
    .out_sum(sum0), .out_ovf(ovf[0])
  );
  mul4_dot_acc #(.N(4), .ACC_W(8)) u_d1 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(ird[1]),
    .x(tx[1]), .y(ty[1]), .out_valid(ov[1]), .out_ready(ordy[1]),
    .out_sum(sum1), .out_ovf(ovf[1])
  );
  mul4_dot_acc #(.N(1), .ACC_W(10)) u_d2 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[2]), .in_ready(ird[2]),
    .x(tx[2]), .y(ty[2]), .out_valid(ov[2]), .out_ready(ordy[2]),
    .out_sum(sum2), .out_ovf(ovf[2])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic int qsize(input int d);
    case (d)
      0:       return q0.size();
      1:       return q1.size();
      default: return q2.size();
    endcase
  endfunction

  // Output monitors: one pop per accepted result
  always @(negedge clk) begin : mon0
    exp_t e;
    if (rst_n && ov[0] && ordy[0]) begin
      if (q0.size() == 0) chk("d0_unexpected_result", 1, 0);
      else begin
        e = q0.pop_front();
        chk("d0_sum", int'(sum0), e.sum);
        chk("d0_ovf", int'(ovf[0]), e.ovf);
      end
    end
  end

  always @(negedge clk) begin : mon1
    exp_t e;
    if (rst_n && ov[1] && ordy[1]) begin
      if (q1.size() == 0) chk("d1_unexpected_result", 1, 0);
      else begin
        e = q1.pop_front();
        chk("d1_sum", int'(sum1), e.sum);
        chk("d1_ovf", int'(ovf[1]), e.ovf);
      end
    end
  end

  always @(negedge clk) begin : mon2
    exp_t e;
    if (rst_n && ov[2] && ordy[2]) begin
      if (q2.size() == 0) chk("d2_unexpected_result", 1, 0);
      else begin
        e = q2.pop_front();
        chk("d2_sum", int'(sum2), e.sum);
        chk("d2_ovf", int'(ovf[2]), e.ovf);
      end
    end
  end

  // Present one pair and hold it until the handshake edge
  task automatic send(input int d, input int xv, input int yv);
    bit ok;
    ok = 1'b0;
    iv[d] = 1'b1;
    tx[d] = 4'(xv);
    ty[d] = 4'(yv);
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (ird[d]) begin
        ok = 1'b1;
        break;
      end
    end
    @(posedge clk);
    #1;
    iv[d] = 1'b0;
    if (!ok) chk("send_timeout", 0, 1);
  endtask

  task automatic push(input int d, input int s, input int o);
    exp_t e;
    e.sum = s;
    e.ovf = o;
    case (d)
      0:       q0.push_back(e);
      1:       q1.push_back(e);
      default: q2.push_back(e);
    endcase
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drain(input int d, input string nm);
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (qsize(d) == 0) break;
    end
    chk(nm, qsize(d), 0);
    idle(1);
  endtask

  initial begin
    int c0;
    rst_n = 1'b0;
    iv    = '0;
    ordy  = '1;
    for (int i = 0; i < 3; i++) begin
      tx[i] = '0;
      ty[i] = '0;
    end

    // Reset state
    #12;
    chk("rst_in_ready", int'(ird), 0);
    chk("rst_out_valid", int'(ov), 0);
    chk("rst_sum0", int'(sum0), 0);
    chk("rst_ovf", int'(ovf), 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    idle(1);
    chk("post_rst_in_ready", int'(ird), 7);

    // Full-scale products, no overflow, latency check
    push(0, 900, 0);
    for (int i = 0; i < 4; i++) send(0, 15, 15);
    @(negedge clk);
    chk("lat_out_valid", int'(ov[0]), 1);
    chk("lat_in_ready", int'(ird[0]), 0);
    drain(0, "t1_drain");

    // Narrow accumulator wraps, then a clean group
    push(1, 132, 1);
    for (int i = 0; i < 4; i++) send(1, 15, 15);
    push(1, 4, 0);
    for (int i = 0; i < 4; i++) send(1, 1, 1);
    drain(1, "t2_drain");

    // Backpressure: result held stable for five cycles
    ordy[0] = 1'b0;
    push(0, 48, 0);
    for (int i = 0; i < 4; i++) send(0, 3, 4);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_out_valid", int'(ov[0]), 1);
      chk("bp_in_ready", int'(ird[0]), 0);
      chk("bp_sum", int'(sum0), 48);
      chk("bp_ovf", int'(ovf[0]), 0);
    end
    @(posedge clk);
    #1 ordy[0] = 1'b1;
    drain(0, "t3_drain");
    idle(3);
    chk("bp_single_result", int'(ov[0]), 0);

    // Bubbles inside a group
    push(0, 44, 0);
    send(0, 3, 5);  idle(2);
    send(0, 0, 9);  idle(1);
    send(0, 7, 2);  idle(3);
    send(0, 15, 1);
    drain(0, "t4_drain");

    // Pending result on d1 and partial group on d0 are both discarded by reset
    ordy[1] = 1'b0;
    for (int i = 0; i < 4; i++) send(1, 1, 1);
    @(negedge clk);
    chk("pend_out_valid", int'(ov[1]), 1);
    send(0, 15, 15);
    send(0, 15, 15);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_in_ready", int'(ird), 0);
    chk("mid_rst_out_valid", int'(ov), 0);
    chk("mid_rst_sum0", int'(sum0), 0);
    chk("mid_rst_sum1", int'(sum1), 0);
    chk("mid_rst_ovf", int'(ovf), 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    ordy[1] = 1'b1;
    push(0, 24, 0);
    for (int i = 0; i < 4; i++) send(0, 2, 3);
    drain(0, "t5_drain");
    idle(2);
    chk("dropped_result_d1", int'(ov[1]), 0);

    // N=1 exhaustive, two cycles per result
    c0 = cyc;
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        push(2, a * b, 0);
        send(2, a, b);
      end
    end
    chk("n1_cycles", cyc - c0, 511);
    drain(2, "t6_drain");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
